// File: rtl/tdm_demux_4t1.sv
// Receive-side TDM demultiplexer: recovers slot alignment from a frame marker
// and rebuilds four channel samples into a parallel frame with a valid pulse.
module tdm_demux_4t1 #(
    parameter int unsigned WIDTH    = 1,
    parameter int unsigned MISS_MAX = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             En,
    input  logic [WIDTH-1:0] Din,
    input  logic             Frame,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] C,
    output logic [WIDTH-1:0] D,
    output logic             Valid,
    output logic [1:0]       Sel,
    output logic             Locked,
    output logic             Sync_err
);

    typedef enum logic [0:0] {
        ST_HUNT = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    localparam logic [2:0] MISS_LIM = 3'(MISS_MAX);

    state_t           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [2:0]       miss_q, miss_d;
    logic [WIDTH-1:0] sh0_q, sh0_d;
    logic [WIDTH-1:0] sh1_q, sh1_d;
    logic [WIDTH-1:0] sh2_q, sh2_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             valid_q, valid_d;
    logic             sync_err_q, sync_err_d;
    logic             locked_q, locked_d;
    logic [2:0]       miss_inc_s;

    assign miss_inc_s = miss_q + 3'd1;

    // Next-state and slot-capture logic; every register holds unless En consumes a slot.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        miss_d     = miss_q;
        sh0_d      = sh0_q;
        sh1_d      = sh1_q;
        sh2_d      = sh2_q;
        a_d        = a_q;
        b_d        = b_q;
        c_d        = c_q;
        d_d        = d_q;
        valid_d    = 1'b0;
        sync_err_d = 1'b0;

        if (En) begin
            case (state_q)
                ST_HUNT: begin
                    if (Frame) begin
                        sh0_d   = Din;
                        sel_d   = 2'd1;
                        miss_d  = 3'd0;
                        state_d = ST_LOCK;
                    end else begin
                        sel_d = 2'd0;
                    end
                end
                ST_LOCK: begin
                    if (Frame) begin
                        // A marker anywhere but slot 0 abandons the partial frame and realigns.
                        if (sel_q != 2'd0) begin
                            sync_err_d = 1'b1;
                        end else begin
                            sync_err_d = 1'b0;
                        end
                        sh0_d  = Din;
                        sel_d  = 2'd1;
                        miss_d = 3'd0;
                    end else begin
                        case (sel_q)
                            2'd0: begin
                                if (miss_inc_s == MISS_LIM) begin
                                    state_d    = ST_HUNT;
                                    sel_d      = 2'd0;
                                    miss_d     = 3'd0;
                                    sync_err_d = 1'b1;
                                end else begin
                                    sh0_d  = Din;
                                    sel_d  = 2'd1;
                                    miss_d = miss_inc_s;
                                end
                            end
                            2'd1: begin
                                sh1_d = Din;
                                sel_d = 2'd2;
                            end
                            2'd2: begin
                                sh2_d = Din;
                                sel_d = 2'd3;
                            end
                            2'd3: begin
                                a_d     = sh0_q;
                                b_d     = sh1_q;
                                c_d     = sh2_q;
                                d_d     = Din;
                                valid_d = 1'b1;
                                sel_d   = 2'd0;
                            end
                            default: begin
                                sel_d = 2'd0;
                            end
                        endcase
                    end
                end
                default: begin
                    state_d = ST_HUNT;
                    sel_d   = 2'd0;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        locked_d = (state_d == ST_LOCK);
    end

    // State, shadow and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_HUNT;
            sel_q      <= 2'd0;
            miss_q     <= 3'd0;
            sh0_q      <= '0;
            sh1_q      <= '0;
            sh2_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= '0;
            d_q        <= '0;
            valid_q    <= 1'b0;
            sync_err_q <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            miss_q     <= miss_d;
            sh0_q      <= sh0_d;
            sh1_q      <= sh1_d;
            sh2_q      <= sh2_d;
            a_q        <= a_d;
            b_q        <= b_d;
            c_q        <= c_d;
            d_q        <= d_d;
            valid_q    <= valid_d;
            sync_err_q <= sync_err_d;
            locked_q   <= locked_d;
        end
    end

    assign A        = a_q;
    assign B        = b_q;
    assign C        = c_q;
    assign D        = d_q;
    assign Valid    = valid_q;
    assign Sel      = sel_q;
    assign Locked   = locked_q;
    assign Sync_err = sync_err_q;

endmodule
